// File: rtl/alu_share_arbiter_pkg.sv
// Core datapath types and the constants used by the shared-ALU arbiter.
// The arbiter and the ALU both build on this package.
package alu_share_arbiter_pkg;

   typedef logic [63:0] data_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
      ALU_DEFAULT
   } alu_op_enum;

   localparam int         ARB_MAX_REQ = 4;
   localparam alu_op_enum ARB_IDLE_OP = ALU_ADD;

   // A W-op produces a 32-bit result that is sign-extended to the full 64-bit width.
   function automatic data_t sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request and response channels between the requesters and the shared-ALU arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface alu_share_arbiter_if
   import alu_share_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int CNT_W = 32
);
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   data_t            req_a [N_REQ];
   data_t            req_b [N_REQ];
   alu_op_enum       req_op [N_REQ];
   logic [N_REQ-1:0] rsp_valid;
   logic [N_REQ-1:0] rsp_ready;
   data_t            rsp_res [N_REQ];
   logic [CNT_W-1:0] grant_cnt;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, grant_cnt
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_res, grant_cnt
   );
endinterface

// File: rtl/alu.sv
// The core's combinational integer ALU.
// The arbiter instantiates it once and shares it between all requesters.
module alu
   import alu_share_arbiter_pkg::*;
(
   input  data_t      i_a,
   input  data_t      i_b,
   input  alu_op_enum i_op,
   output data_t      o_res
);
   logic [31:0] w_addw;
   logic [31:0] w_subw;
   logic [31:0] w_sllw;
   logic [31:0] w_srlw;
   logic [31:0] w_sraw;

   assign w_addw = i_a[31:0] + i_b[31:0];
   assign w_subw = i_a[31:0] - i_b[31:0];
   assign w_sllw = i_a[31:0] << i_b[4:0];
   assign w_srlw = i_a[31:0] >> i_b[4:0];
   assign w_sraw = $signed(i_a[31:0]) >>> i_b[4:0];

   always_comb begin
      o_res = '0;
      case (i_op)
         ALU_ADD:  o_res = i_a + i_b;
         ALU_SUB:  o_res = i_a - i_b;
         ALU_AND:  o_res = i_a & i_b;
         ALU_OR:   o_res = i_a | i_b;
         ALU_XOR:  o_res = i_a ^ i_b;
         ALU_SLL:  o_res = i_a << i_b[5:0];
         ALU_SRL:  o_res = i_a >> i_b[5:0];
         ALU_SRA:  o_res = $signed(i_a) >>> i_b[5:0];
         ALU_SLT:  o_res = {63'd0, $signed(i_a) < $signed(i_b)};
         ALU_SLTU: o_res = {63'd0, i_a < i_b};
         ALU_ADDW: o_res = sext32(w_addw);
         ALU_SUBW: o_res = sext32(w_subw);
         ALU_SLLW: o_res = sext32(w_sllw);
         ALU_SRLW: o_res = sext32(w_srlw);
         ALU_SRAW: o_res = sext32(w_sraw);
         default:  o_res = '0;
      endcase
   end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder.
// It returns a one-hot grant for the first eligible index, scanning from i_rr_ptr upward and wrapping.
module rr_pick #(
   parameter int N_REQ = 2,
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_eligible,
   input  logic [PW-1:0]    i_rr_ptr,
   output logic [N_REQ-1:0] o_grant
);
   function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] elig,
                                             input logic [PW-1:0]    ptr);
      logic [N_REQ-1:0] g;
      logic             found;
      logic [PW-1:0]    idx;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = PW'((int'(ptr) + k) % N_REQ);
         if (!found && elig[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

   assign o_grant = pick(i_eligible, i_rr_ptr);
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between N_REQ requesters with round-robin grants.
// Each requester has a one-entry registered result slot; a grant counter is kept for performance monitoring.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int CNT_W = 32,
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_share_arbiter_if.slave   bus
);
   logic [N_REQ-1:0] r_rsp_valid;
   data_t            r_rsp_res [N_REQ];
   logic [PW-1:0]    r_rr_ptr;
   logic [CNT_W-1:0] r_grant_cnt;

   logic [N_REQ-1:0] w_slot_free;
   logic [N_REQ-1:0] w_eligible;
   logic [N_REQ-1:0] w_grant;
   logic             w_any;
   logic [PW-1:0]    w_gidx;
   data_t            w_alu_a;
   data_t            w_alu_b;
   alu_op_enum       w_alu_op;
   data_t            w_alu_res;

   // A slot that is being drained this cycle can be refilled in the same cycle.
   assign w_slot_free = ~r_rsp_valid | bus.rsp_ready;
   assign w_eligible  = bus.req_valid & w_slot_free;
   assign w_any       = |w_grant;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .i_eligible (w_eligible),
      .i_rr_ptr   (r_rr_ptr),
      .o_grant    (w_grant)
   );

   // Only the granted requester's operands reach the ALU, so other requesters' inputs cannot affect any state.
   always_comb begin
      w_alu_a  = '0;
      w_alu_b  = '0;
      w_alu_op = ARB_IDLE_OP;
      w_gidx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_alu_a  = bus.req_a[i];
            w_alu_b  = bus.req_b[i];
            w_alu_op = bus.req_op[i];
            w_gidx   = PW'(i);
         end
      end
   end

   alu u_alu (
      .i_a   (w_alu_a),
      .i_b   (w_alu_b),
      .i_op  (w_alu_op),
      .o_res (w_alu_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= '0;
         for (int i = 0; i < N_REQ; i++) r_rsp_res[i] <= '0;
         r_rr_ptr    <= '0;
         r_grant_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
               r_rsp_valid[i] <= 1'b1;
               r_rsp_res[i]   <= w_alu_res;
            end else if (bus.rsp_ready[i]) begin
               r_rsp_valid[i] <= 1'b0;
            end
         end
         if (w_any) begin
            r_rr_ptr    <= (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + PW'(1);
            r_grant_cnt <= r_grant_cnt + CNT_W'(1);
         end
      end
   end

   // req_ready depends combinationally on req_valid and rsp_ready.
   assign bus.req_ready = w_grant;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_res   = r_rsp_res;
   assign bus.grant_cnt = r_grant_cnt;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter (3 requesters, 4-bit grant counter).
// A queue-free reference model tracks the slots, the round-robin pointer and the counter.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int NR = 3;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.N_REQ(NR), .CNT_W(CW)) bus ();

   alu_share_arbiter #(.N_REQ(NR), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic          m_vld [NR];
   logic [63:0]   m_res [NR];
   int            m_ptr;
   int            m_cnt;
   logic [NR-1:0] seen_ready;
   int            last_g;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] ref_alu(input alu_op_enum op, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32;
      a32 = a[31:0];
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a + ~b + 64'd1;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[5:0];
         ALU_SRL:  return a >> b[5:0];
         ALU_SRA:  return 64'($signed(a) >>> b[5:0]);
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         ALU_SLTU: return (a < b) ? 64'd1 : 64'd0;
         ALU_ADDW: return sx(32'(a + b));
         ALU_SUBW: return sx(32'(a - b));
         ALU_SLLW: return sx(a32 << b[4:0]);
         ALU_SRLW: return sx(a32 >> b[4:0]);
         ALU_SRAW: return sx(32'($signed(a32) >>> b[4:0]));
         default:  return 64'd0;
      endcase
   endfunction

   task automatic set_req(input int i, input logic v, input alu_op_enum op,
                          input logic [63:0] a, input logic [63:0] b);
      bus.req_valid[i] = v;
      bus.req_op[i]    = op;
      bus.req_a[i]     = a;
      bus.req_b[i]     = b;
   endtask

   // One clock: predict and check the grant mid-cycle, advance the model at the edge, check registered outputs after it.
   task automatic step();
      int g;
      int idx;
      logic [NR-1:0] eg;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NR; k++) begin
         idx = (m_ptr + k) % NR;
         if (g < 0 && bus.req_valid[idx] && (!m_vld[idx] || bus.rsp_ready[idx])) g = idx;
      end
      eg = (g >= 0) ? NR'(1 << g) : '0;
      seen_ready = bus.req_ready;
      last_g     = g;
      check_val("req_ready", 64'(bus.req_ready), 64'(eg));
      if (rst) begin
         for (int i = 0; i < NR; i++) begin m_vld[i] = 1'b0; m_res[i] = '0; end
         m_ptr = 0;
         m_cnt = 0;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (i == g) begin
               m_vld[i] = 1'b1;
               m_res[i] = ref_alu(bus.req_op[i], bus.req_a[i], bus.req_b[i]);
            end else if (bus.rsp_ready[i]) begin
               m_vld[i] = 1'b0;
            end
         end
         if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            m_cnt = (m_cnt + 1) % (1 << CW);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         check_val($sformatf("rsp_valid%0d", i), 64'(bus.rsp_valid[i]), 64'(m_vld[i]));
         check_val($sformatf("rsp_res%0d", i), bus.rsp_res[i], m_res[i]);
      end
      check_val("grant_cnt", 64'(bus.grant_cnt), 64'(m_cnt));
   endtask

   task automatic idle_all();
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, ALU_ADD, 64'($urandom), 64'($urandom));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   int seq [4];

   initial begin
      for (int i = 0; i < NR; i++) begin m_vld[i] = 1'b0; m_res[i] = '0; end
      m_ptr = 0;
      m_cnt = 0;
      idle_all();
      bus.rsp_ready = '0;
      step();
      do_reset();
      check_val("reset_cnt", 64'(bus.grant_cnt), 64'd0);
      check_val("reset_valid", 64'(bus.rsp_valid), 64'd0);

      // single op
      bus.rsp_ready = 3'b001;
      set_req(0, 1'b1, ALU_SUB, 64'd5, 64'd3);
      step();
      check_val("single_ready", 64'(seen_ready), 64'b001);
      check_val("single_res", bus.rsp_res[0], 64'd2);
      check_val("single_cnt", 64'(bus.grant_cnt), 64'd1);
      idle_all();
      step();

      // contention after reset
      do_reset();
      bus.rsp_ready = 3'b111;
      set_req(0, 1'b1, ALU_ADD, 64'd1, 64'd2);
      set_req(1, 1'b1, ALU_XOR, 64'hF0, 64'hFF);
      for (int c = 0; c < 4; c++) begin
         step();
         seq[c] = last_g;
      end
      for (int c = 0; c < 4; c++) check_val($sformatf("cont_grant%0d", c), 64'(seq[c]), 64'(c % 2));
      check_val("cont_res0", bus.rsp_res[0], 64'd3);
      check_val("cont_res1", bus.rsp_res[1], 64'h0F);
      check_val("cont_cnt", 64'(bus.grant_cnt), 64'd4);
      idle_all();
      step();

      // backpressure on requester 1
      bus.rsp_ready = 3'b000;
      set_req(1, 1'b1, ALU_SLLW, 64'd1, 64'd31);
      step();
      set_req(1, 1'b1, ALU_ADD, 64'd7, 64'd8);
      for (int c = 0; c < 2; c++) begin
         step();
         check_val("bp_stall", 64'(seen_ready[1]), 64'd0);
         check_val("bp_hold", bus.rsp_res[1], 64'hFFFF_FFFF_8000_0000);
      end
      bus.rsp_ready = 3'b010;
      step();
      check_val("bp_accept", 64'(seen_ready[1]), 64'd1);
      check_val("bp_nogap", 64'(bus.rsp_valid[1]), 64'd1);
      check_val("bp_res2", bus.rsp_res[1], 64'd15);
      idle_all();
      step();

      // drain only
      bus.rsp_ready = 3'b000;
      set_req(0, 1'b1, ALU_ADD, 64'd9, 64'd9);
      step();
      set_req(0, 1'b0, ALU_SUB, 64'd100, 64'd1);
      bus.rsp_ready = 3'b001;
      step();
      check_val("drain_valid", 64'(bus.rsp_valid[0]), 64'd0);
      check_val("drain_res", bus.rsp_res[0], 64'd18);

      // reset while both slots are full
      bus.rsp_ready = 3'b000;
      set_req(0, 1'b1, ALU_OR, 64'h3, 64'h4);
      set_req(1, 1'b1, ALU_AND, 64'h6, 64'h3);
      step();
      step();
      check_val("mid_full", 64'(bus.rsp_valid), 64'b011);
      do_reset();
      check_val("mid_valid", 64'(bus.rsp_valid), 64'd0);
      check_val("mid_cnt", 64'(bus.grant_cnt), 64'd0);
      bus.rsp_ready = 3'b111;
      step();
      check_val("mid_first", 64'(seen_ready), 64'b001);
      idle_all();
      step();

      // counter wrap: 17 accepted requests on a 4-bit counter
      do_reset();
      bus.rsp_ready = 3'b111;
      set_req(0, 1'b1, ALU_ADD, 64'd1, 64'd1);
      for (int c = 0; c < 17; c++) begin
         step();
         check_val("wrap_accept", 64'(seen_ready[0]), 64'd1);
      end
      check_val("wrap_cnt", 64'(bus.grant_cnt), 64'd1);
      idle_all();
      step();

      // randomized traffic with occasional reset
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++)
            set_req(i, 1'($urandom_range(0, 99) < 60), alu_op_enum'($urandom_range(0, 15)),
                    {32'($urandom), 32'($urandom)},
                    ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 70)) : {32'($urandom), 32'($urandom)});
         bus.rsp_ready = NR'($urandom);
         rst = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one instance of the core's combinational ALU between N_REQ requesters, for example the integer pipe and a branch/address-compute unit. Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, one grant per cycle.
- Each requester has a one-entry registered response slot, so the result appears one cycle after acceptance.
- A free-running grant counter is exposed for performance monitoring.

Parameters:
- N_REQ, 2: number of requesters; legal range 2..4.
- CNT_W, 32: width of the grant counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request i presents operands.
- req_ready  out  N_REQ  request i accepted this cycle.
- req_a  in  N_REQ x data_t(64)  operand a per requester.
- req_b  in  N_REQ x data_t(64)  operand b per requester.
- req_op  in  N_REQ x alu_op_enum  operation per requester.
- rsp_valid  out  N_REQ  response slot i holds a result.
- rsp_ready  in  N_REQ  requester i consumes its result.
- rsp_res  out  N_REQ x data_t(64)  registered result for requester i.
- grant_cnt  out  CNT_W  total accepted requests since reset.

Behaviour:
- Reset (rst=1 at a clock edge, regardless of in-flight state):
  - rsp_valid = 0, rsp_res = 0, grant_cnt = 0.
  - Round-robin pointer rr_ptr = 0.
  - Any result sitting in a slot is discarded.
- Slot free condition: slot_free[i] = !rsp_valid[i] || rsp_ready[i]. A drain and a refill of the same slot in one cycle are allowed.
- Eligibility: eligible[i] = req_valid[i] && slot_free[i].
- Grant selection (combinational):
  - Pick the first eligible index, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - At most one req_ready bit is high per cycle.
  - req_ready[i] = grant[i].
  - req_ready may depend combinationally on req_valid and rsp_ready. This path is accepted and documented.
- ALU drive:
  - The shared ALU receives the granted requester's a, b and op.
  - With no grant it receives a=0, b=0, op=ALU_ADD. The result is unused.
- On a grant to requester g at edge T:
  - rsp_res[g] <= ALU result.
  - rsp_valid[g] <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
  - grant_cnt <= grant_cnt + 1, wrapping modulo 2^CNT_W with no saturation.
- No grant: rr_ptr and grant_cnt hold.
- Slot drain: rsp_valid[i]=1 && rsp_ready[i]=1 && no grant to i -> rsp_valid[i] <= 0. rsp_res[i] holds its last value.
- Slot hold: rsp_valid[i]=1 && rsp_ready[i]=0 -> rsp_res[i] and rsp_valid[i] are stable. Requester i gets no grant until the slot frees.
- Latency and throughput:
  - Exactly 1 cycle from acceptance to rsp_valid.
  - Aggregate throughput 1 op/cycle.
  - Per-requester throughput 1 op/cycle when its rsp_ready is held high.
- Arithmetic: results are exactly those of the shared ALU. This includes W-ops sign-extended from 32 bits, shift amounts b[5:0] and b[4:0], and ALU_DEFAULT giving 0. The arbiter never modifies operands.
- Fairness: a continuously eligible requester is granted within N_REQ cycles.
- X-safety: req_a, req_b and req_op of non-granted requesters must not affect any state.
- A request with req_valid=0 is never granted, whatever its operand values.

Decomposition:
- Shared package CorePack: data_t and alu_op_enum (existing). Add the constants ARB_MAX_REQ=4 and ARB_IDLE_OP=ALU_ADD.
- Local logic: rr_ptr width is $clog2(N_REQ).
- Sub-modules:
  - The existing ALU module, instantiated once as the shared datapath.
  - One natural helper sub-module, rr_pick: a combinational round-robin first-one finder with inputs eligible and rr_ptr, and a one-hot output grant.

Test Plan:
- Single op: reset, then req0 {a=5, b=3, op=ALU_SUB}, rsp_ready0=1.
  - Response: req_ready0=1 in the same cycle.
  - Next cycle: rsp_valid0=1, rsp_res0=2, grant_cnt=1.
- Contention: req0 {ADD 1,2} and req1 {XOR 0xF0,0xFF} both held valid for 4 cycles, rsp_ready all 1.
  - Response: grants alternate 0,1,0,1.
  - Results are 3 and 0x0F.
  - grant_cnt=4.
- Backpressure: req1 {SLLW 1,31} accepted while rsp_ready1=0.
  - Response: rsp_res1=0xFFFFFFFF80000000 holds.
  - A second req1 sees req_ready1=0 until rsp_ready1=1. It is then accepted in that same drain cycle.
  - rsp_valid1 stays 1 with no gap.
- Drain only: rsp_valid0=1, rsp_ready0=1, req_valid0=0.
  - Response: next cycle rsp_valid0=0 and rsp_res0 unchanged.
- Reset mid-flight: rst=1 for one cycle while rsp_valid0 and rsp_valid1 are 1.
  - Response: rsp_valid=0, grant_cnt=0, rr_ptr=0.
  - The next simultaneous request from both requesters grants req0 first.
- Counter wrap: with CNT_W=4, perform 17 accepted requests.
  - Response: grant_cnt=1, with no stall or error.
